// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register offsets,
// CONTROL/STATUS bit positions and the per-channel write-strobe bundle.
package multi_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_SNAP    = 3'd3;
  localparam logic [2:0] REG_PRESC   = 3'd4;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
    logic presc;
  } reg_wr_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaled down-counter with reload, RUN/TO flags,
// snapshot capture and its register file, driven by decoded write strobes.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRESC_W      = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h5F5E0F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  reg_wr_t     wr,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        tick_out
);

  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
  logic               tick_out_q, tick_out_d;
  logic               tick, evt, start, stop;
  logic               unused_wdata;

  assign unused_wdata = ^wdata;

  always_comb begin
    tick       = run_q && (pcnt_q == presc_q);
    evt        = tick && (cnt_q == '0);
    start      = wr.control && wdata[CTL_START];
    stop       = wr.control && wdata[CTL_STOP];
    cnt_d      = cnt_q;
    period_d   = period_q;
    snap_d     = snap_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q + PRESC_W'(1);
    run_d      = run_q;
    to_d       = to_q;
    cont_d     = cont_q;
    ito_d      = ito_q;
    tick_out_d = evt;

    if (tick) cnt_d = evt ? period_q : cnt_q - CNT_W'(1);
    if (!run_q || tick || start) pcnt_d = '0;
    if (evt && !cont_q) run_d = 1'b0;
    if (evt) to_d = 1'b1;
    // Clearing TO beats a simultaneous timeout so software never loses a clear.
    if (wr.status) to_d = 1'b0;
    if (wr.control) begin
      cont_d = wdata[CTL_CONT];
      ito_d  = wdata[CTL_ITO];
    end
    if (stop)  run_d = 1'b0;
    if (start) run_d = 1'b1;
    if (wr.snap) snap_d = cnt_q;
    // Restart the prescale phase so a smaller PRESC cannot leave pcnt beyond it.
    if (wr.presc) begin
      presc_d = wdata[PRESC_W-1:0];
      pcnt_d  = '0;
    end
    if (wr.period) begin
      period_d = wdata[CNT_W-1:0];
      cnt_d    = wdata[CNT_W-1:0];
      run_d    = 1'b0;
      pcnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= RST_CNT;
      period_q   <= RST_CNT;
      snap_q     <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      cont_q     <= 1'b0;
      ito_q      <= 1'b0;
      tick_out_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      run_q      <= run_d;
      to_q       <= to_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      tick_out_q <= tick_out_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_STATUS: begin
        rd_data[STS_RUN] = run_q;
        rd_data[STS_TO]  = to_q;
      end
      REG_CONTROL: begin
        rd_data[CTL_CONT] = cont_q;
        rd_data[CTL_ITO]  = ito_q;
      end
      REG_PERIOD: rd_data[CNT_W-1:0]   = period_q;
      REG_SNAP:   rd_data[CNT_W-1:0]   = snap_q;
      REG_PRESC:  rd_data[PRESC_W-1:0] = presc_q;
      default:    rd_data = '0;
    endcase
  end

  assign irq      = to_q && ito_q;
  assign tick_out = tick_out_q;

endmodule

// File: rtl/avalon_multi_interval_timer.sv
// N-channel Avalon-MM interval timer: address decode into per-channel write
// strobes, registered read mux and the shared interrupt.
module avalon_multi_interval_timer
  import multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int          PRESC_W      = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h5F5E0F,
  localparam int         ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tick_out
);

  logic [ADDR_W-1:0] ch_addr;
  logic [2:0]        reg_sel;
  logic              wr_en;
  logic [31:0]       rd_mux;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       ch_rd [NUM_CH];
  reg_wr_t           ch_wr [NUM_CH];

  // Shift instead of slicing so a single-channel build has no zero-width field.
  assign ch_addr = address >> 3;
  assign reg_sel = address[2:0];
  assign wr_en   = chipselect && !write_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic hit;
      assign hit = wr_en && (ch_addr == ADDR_W'(gi));
      assign ch_wr[gi] = '{status:  hit && (reg_sel == REG_STATUS),
                           control: hit && (reg_sel == REG_CONTROL),
                           period:  hit && (reg_sel == REG_PERIOD),
                           snap:    hit && (reg_sel == REG_SNAP),
                           presc:   hit && (reg_sel == REG_PRESC)};

      timer_channel #(
        .CNT_W       (CNT_W),
        .PRESC_W     (PRESC_W),
        .RESET_PERIOD(RESET_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (ch_wr[gi]),
        .wdata   (writedata),
        .rd_sel  (reg_sel),
        .rd_data (ch_rd[gi]),
        .irq     (irq_vec[gi]),
        .tick_out(tick_out[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_addr == ADDR_W'(i)) rd_mux = ch_rd[i];
    end
    readdata_d = rd_mux;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule
